count_display_mux: RTL and testbench
====================================

// Module: count_display_mux
// PURPOSE
//  Downstream consumer of the 0..99 timer counter: converts the 8-bit binary count
//  to two BCD digits with a sequential double-dabble engine and drives a
//  time-multiplexed two-digit seven-segment display. Sits between the counter
//  output and the board's segment/anode pins.
// PARAMETERS
//  REFRESH_DIV     50000  clk cycles each digit stays lit before switching; legal >= 2
//  SEG_ACTIVE_LOW  1      1: seg and an driven active-low; 0: active-high
// PORTS
//  clk    input   1  system clock, all logic on rising edge
//  reset  input   1  asynchronous, active-low reset
//  count  input   8  binary value from counter, legal 0..99; other values are flagged
//  seg    output  7  segments {g,f,e,d,c,b,a} for the currently selected digit
//  an     output  2  one-hot digit enable; an[0]=units, an[1]=tens
//  busy   output  1  high while a conversion is in progress
// BEHAVIOUR
//  - Reset is asynchronous and active-low. Reset values: FSM IDLE; tens=0, units=0;
//    valid=0; refresh divider=0; sel=units; busy=0.
//    Outputs show '0' on units (an=units), subject to polarity.
//  - Reset asserted mid-conversion: the conversion aborts and the digits return to 0.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE: if !valid or count != last_val, at that edge (E):
//      * load the 20-bit scratch {12'b0,count};
//      * capture last_val=count;
//      * shift counter=0; go to SHIFT.
//    SHIFT: each edge, add 3 to any BCD nibble >= 5, then shift the scratch left by 1.
//      After the 8th shift (edge E+8), go to DONE.
//    DONE (edge E+9): latch tens/units from BCD nibbles; set valid=1; go to IDLE.
//      If the hundreds nibble is nonzero (count > 99), set the error flag instead.
//  - busy=1 from edge E through E+9 inclusive; it is a registered output.
//    Latency: count stable before E -> new digits visible after E+9 (10 cycles).
//  - count changes while busy are ignored. The next IDLE compares again, so the
//    final stable value is always converted.
//    Back-to-back: IDLE -> SHIFT may occur on the edge after DONE.
//  - Encoding (active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//    Error glyph '-'=40 on both digits.
//  - Refresh: the divider counts 0..REFRESH_DIV-1. At terminal count it wraps to 0
//    and sel toggles. an is one-hot from sel and seg selects that digit's glyph.
//    seg/an are registered, with no glitch between digits.
//  - SEG_ACTIVE_LOW=1: seg and an are bitwise inverted at the output register.
//  - The refresh path runs independently of conversion. Digits update atomically
//    at DONE, so a half-updated value is never displayed.
// CONFIGURATION
//  BLANK_LEADING_ZERO_EN defined: when tens==0 and no error, the tens digit shows
//    all segments off (an still cycles). Example: 7 displays " 7"; 0 displays " 0".
//  Not defined: the tens digit always shows its glyph. Example: 7 displays "07".
// TESTING
//  1. reset=0, count=0 -> seg=~3F, an=2'b10 (active-low), busy=0.
//     Release reset -> busy high for 10 cycles, then the display reads "00".
//  2. count=47 held -> busy for 10 cycles. Then units phase seg=~07 an=2'b10;
//     tens phase seg=~66 an=2'b01.
//  3. count 99 then wrap to 0 -> "99" then "00". Each update lands exactly 10 cycles
//     after the value is stable at the IDLE edge.
//  4. count=12, changed to 34 at E+3 -> "12" shown after E+9.
//     Second conversion starts at E+10; "34" shown after E+19.
//  5. count=150 -> both digits show seg=~40. Returning to count=8 -> "08"
//     (" 8" with BLANK_LEADING_ZERO_EN defined).
//  6. REFRESH_DIV=4 -> an toggles every 4 cycles. reset pulsed at E+5 mid-conversion
//     -> busy=0 and digits=0 immediately; after release, the conversion reruns.

Source files
------------

// File: rtl/count_display_mux.sv
// Binary 0..99 count to two BCD digits (sequential double-dabble) driving a
// multiplexed two-digit seven-segment display. Optional: BLANK_LEADING_ZERO_EN.
module count_display_mux #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       busy
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_RST = SEG_ACTIVE_LOW ? ~7'h3F : 7'h3F;
  localparam logic [1:0] AN_RST  = SEG_ACTIVE_LOW ? ~2'b01 : 2'b01;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [19:0]       scratch_q, scratch_d;
  logic [7:0]        last_q, last_d;
  logic [2:0]        shift_q, shift_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        units_q, units_d;
  logic              busy_q, busy_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              sel_q, sel_d;
  logic [6:0]        seg_q, seg_d;
  logic [1:0]        an_q, an_d;
  logic [19:0]       adj;
  logic [6:0]        tens_glyph, units_glyph, cur_glyph;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    last_d    = last_q;
    shift_d   = shift_q;
    valid_d   = valid_q;
    err_d     = err_q;
    tens_d    = tens_q;
    units_d   = units_q;
    busy_d    = 1'b0;
    adj       = scratch_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (adj[8+4*i +: 4] >= 4'd5) adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (!valid_q || count != last_q) begin
          scratch_d = {12'b0, count};
          last_d    = count;
          shift_d   = '0;
          state_d   = SHIFT;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        scratch_d = {adj[18:0], 1'b0};
        shift_d   = shift_q + 3'd1;
        busy_d    = 1'b1;
        if (shift_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
        state_d = IDLE;
        if (scratch_q[19:16] != 4'd0) begin
          err_d = 1'b1;
        end else begin
          err_d   = 1'b0;
          tens_d  = scratch_q[15:12];
          units_d = scratch_q[11:8];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register is fed from next-state digits and select, so a new
  // value and the digit switch land on the same edge as their cause.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    sel_d = (div_q == DIV_LAST) ? ~sel_q : sel_q;
    units_glyph = err_d ? 7'h40 : glyph(units_d);
    tens_glyph  = err_d ? 7'h40 : glyph(tens_d);
`ifdef BLANK_LEADING_ZERO_EN
    if (!err_d && tens_d == 4'd0) tens_glyph = 7'h00;
`endif
    cur_glyph = sel_d ? tens_glyph : units_glyph;
    an_d      = sel_d ? 2'b10 : 2'b01;
    if (SEG_ACTIVE_LOW) begin
      seg_d = ~cur_glyph;
      an_d  = ~an_d;
    end else begin
      seg_d = cur_glyph;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      last_q    <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      tens_q    <= '0;
      units_q   <= '0;
      busy_q    <= 1'b0;
      div_q     <= '0;
      sel_q     <= 1'b0;
      seg_q     <= SEG_RST;
      an_q      <= AN_RST;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      last_q    <= last_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      busy_q    <= busy_d;
      div_q     <= div_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_count_display_mux.sv
// Directed + random bench for count_display_mux (REFRESH_DIV=4, active-low).
// Honours BLANK_LEADING_ZERO_EN in its display model.
module tb_count_display_mux;

  localparam int unsigned RDIV = 4;

  logic       clk;
  logic       reset;
  logic [7:0] count;
  logic [6:0] seg;
  logic [1:0] an;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int last_v      = 0;

  logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  count_display_mux #(.REFRESH_DIV(RDIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .count (count),
    .seg   (seg),
    .an    (an),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-high glyph the display should show for value v on one digit.
  function automatic logic [6:0] exp_glyph(input int v, input bit tens);
    int d;
    if (v > 99) return 7'h40;
    d = tens ? v / 10 : v % 10;
`ifdef BLANK_LEADING_ZERO_EN
    if (tens && d == 0) return 7'h00;
`endif
    return glyph_tab[d];
  endfunction

  task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input int v, input string tag);
    logic [6:0] e;
    chk({15'b0, an[1] ^ an[0]}, 16'd1, {tag, "_an_onehot"});
    e = (an === 2'b01) ? ~exp_glyph(v, 1'b1) : ~exp_glyph(v, 1'b0);
    chk({9'b0, seg}, {9'b0, e}, {tag, "_seg"});
  endtask

  task automatic check_disp(input int v, input string tag);
    bit saw_u = 1'b0;
    bit saw_t = 1'b0;
    repeat (2 * RDIV + 2) begin
      @(negedge clk);
      check_now(v, tag);
      if (an === 2'b10) saw_u = 1'b1;
      if (an === 2'b01) saw_t = 1'b1;
    end
    chk({14'b0, saw_u, saw_t}, 16'd3, {tag, "_both_phases"});
  endtask

  // Called at a negedge with the DUT idle and a conversion due on the next edge.
  task automatic expect_conv(input int nv, input int ov, input string tag);
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk({15'b0, busy}, 16'd1, {tag, "_busy"});
      if (k == 8) check_now(ov, {tag, "_old"});
      if (k == 9) check_now(nv, {tag, "_new"});
    end
  endtask

  task automatic conv(input int v, input string tag);
    count = 8'(v);
    expect_conv(v, last_v, tag);
    @(negedge clk);
    chk({15'b0, busy}, 16'd0, {tag, "_idle"});
    check_disp(v, tag);
    last_v = v;
  endtask

  initial begin
    int v;
    reset = 1'b0;
    count = 8'd0;
    repeat (2) @(negedge clk);
    chk({9'b0, seg}, {9'b0, ~7'h3F}, "rst_seg");
    chk({14'b0, an}, 16'b10, "rst_an");
    chk({15'b0, busy}, 16'd0, "rst_busy");

    reset = 1'b1;
    expect_conv(0, 0, "rst_conv");
    @(negedge clk);
    chk({15'b0, busy}, 16'd0, "rst_conv_idle");
    check_disp(0, "rst_conv");
    last_v = 0;

    conv(47, "c47");
    conv(99, "c99");
    conv(0, "c00");

    // Change during busy is ignored until the next IDLE comparison.
    count = 8'd12;
    @(posedge clk);
    repeat (3) @(negedge clk);
    count = 8'd34;
    repeat (7) @(negedge clk);
    chk({15'b0, busy}, 16'd1, "chg_busy");
    check_now(12, "chg_first");
    expect_conv(34, 12, "chg_second");
    @(negedge clk);
    chk({15'b0, busy}, 16'd0, "chg_idle");
    check_disp(34, "chg_second");
    last_v = 34;

    conv(150, "err150");
    conv(8, "c08");

    for (int i = 0; i < 12; i++) begin
      v = int'($urandom_range(0, 127));
      if (v == last_v) v = (v + 1) % 128;
      conv(v, $sformatf("rnd%0d_%0d", i, v));
    end

    // Asynchronous reset in the middle of a conversion.
    v = (last_v == 55) ? 56 : 55;
    count = 8'(v);
    @(posedge clk);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk({15'b0, busy}, 16'd0, "mid_rst_busy");
    chk({9'b0, seg}, {9'b0, ~7'h3F}, "mid_rst_seg");
    chk({14'b0, an}, 16'b10, "mid_rst_an");
    repeat (2) @(negedge clk);
    chk({15'b0, busy}, 16'd0, "mid_rst_hold_busy");
    reset = 1'b1;
    expect_conv(v, 0, "rerun");
    @(negedge clk);
    chk({15'b0, busy}, 16'd0, "rerun_idle");
    check_disp(v, "rerun");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
